dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
MEM-stage data-memory access unit for the pipelined RV32I core. It consumes the EX/MEM latch contents: the control word's mem_read, mem_write, store_formatter_op and load_formatter_op fields, plus the ALU address and rs2 data. It drives a request/response data-memory port and produces the formatted load value for the WB stage. It also provides the MEM_ready stall signal that freezes upstream latches until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ACCESS without dmem_resp before abort (used only with DMEM_TIMEOUT_EN)
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX/MEM latch holds a valid instruction
mem_read  in  1  control word mem_read
mem_write  in  1  control word mem_write
store_op  in  3  store_funct3_t (sb/sh/sw)
load_op  in  3  load_funct3_t (lb/lh/lw/lbu/lhu)
addr  in  32  byte address from ALU
store_data  in  32  rs2 value
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_address  out  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated write data
dmem_byte_enable  out  4  byte mask
dmem_rdata  in  32  read data, valid with dmem_resp
dmem_resp  in  1  single-cycle completion pulse
load_result  out  32  formatted load value, registered
mem_ready  out  1  1 = MEM stage may advance
access_fault  out  1  misaligned/illegal access, registered, one-cycle pulse

Behaviour:
- Reset: state IDLE; dmem_read=dmem_write=0; dmem_address, dmem_wdata, load_result = 0; dmem_byte_enable=0; access_fault=0. Reset mid-ACCESS drops the request immediately. No response is captured.
- op = ex_valid & (mem_read | mem_write). If both are set, write wins and the read is ignored.
- Illegal conditions:
  - load_op in {011,110,111}, or store_op >= 011.
  - lw/sw with addr[1:0]!=0.
  - lh/lhu/sh with addr[0]!=0.
- FSM IDLE:
  - No op: mem_ready=1.
  - Op and illegal: no request; next cycle DONE with access_fault=1 and load_result=0.
  - Op and legal: register request outputs; next state ACCESS; mem_ready=0.
- FSM ACCESS:
  - dmem_read/dmem_write held high; address, wdata and byte enable held stable; mem_ready=0.
  - On dmem_resp: deassert request the next cycle; for reads, register the formatted dmem_rdata into load_result; next state DONE.
- FSM DONE: mem_ready=1 for exactly one cycle, then IDLE. Inputs are not re-sampled in DONE, so a stalled instruction is never issued twice.
- Minimum legal-access latency: op seen in cycle N, request high from N+1, resp at N+1 earliest, mem_ready at N+2.
- dmem_resp outside ACCESS is ignored.
- Byte enable:
  - sb: 4'b0001<<addr[1:0]
  - sh: 4'b0011<<addr[1:0]
  - sw and all reads: 4'b1111
- Write data: sb replicates the byte 4x; sh replicates the halfword 2x; sw passes through.
- Load format, using the lane selected by addr[1:0] latched at issue:
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- load_result holds its value until the next completed read. Stores do not modify it.

Optional Feature:
DMEM_TIMEOUT_EN.
- Defined: a CNT_W counter clears on entry to ACCESS and increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES with no resp:
  - request deasserts;
  - access_fault pulses;
  - load_result becomes 32'h0;
  - state moves to DONE.
- A dmem_resp arriving in the same cycle as the timeout wins, and the access completes normally.
- Undefined: ACCESS waits indefinitely and no counter exists.

Test Plan:
- lb with addr=0x1003, rdata=0x80FF_1234, resp after 3 cycles -> dmem_address=0x1000, byte_enable=1111, load_result=0xFFFF_FF80, mem_ready low 4 cycles then high 1 cycle.
- sh with addr=0x2002, store_data=0x0000_ABCD -> dmem_write=1, byte_enable=1100, wdata=0xABCD_ABCD, load_result unchanged.
- lw with addr=0x3001 -> no dmem request, access_fault=1 for one cycle, load_result=0, mem_ready=1 in DONE.
- lhu with addr=0x10, rdata=0x8001_F00F, resp the same cycle request rises -> load_result=0x0000_F00F at N+2, request high exactly one cycle.
- rst asserted mid-ACCESS, then resp pulses after release -> outputs zero asynchronously, FSM in IDLE, the stray resp is ignored and load_result stays 0.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no resp -> request drops after 4 ACCESS cycles, access_fault pulses, mem_ready=1 the next cycle.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Data-memory request/response port.
//   master (access unit): drives dmem_read, dmem_write, dmem_address, dmem_wdata,
//                         dmem_byte_enable; receives dmem_rdata, dmem_resp.
//   slave  (memory)     : the mirror image.
interface dmem_access_unit_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit for the pipelined RV32I core.
// Turns the EX/MEM latch (mem_read/mem_write, store/load funct3, ALU address,
// rs2 data) into a word-aligned request on the dmem port, formats load data
// for WB and stalls upstream through mem_ready until the access finishes.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ex_valid, mem_read, mem_write, store_op, load_op, addr, store_data
//                       EX/MEM latch contents
//   dmem                request/response data-memory port (master side)
//   load_result         formatted load value (registered)
//   mem_ready           1 = MEM stage may advance
//   access_fault        one-cycle pulse for misaligned/illegal (or timed-out) access
// Optional feature macro: DMEM_TIMEOUT_EN -- aborts an ACCESS after
// TIMEOUT_CYCLES cycles without dmem_resp.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           store_op,
  input  logic [2:0]           load_op,
  input  logic [31:0]          addr,
  input  logic [31:0]          store_data,
  dmem_access_unit_if.master   dmem,
  output logic [31:0]          load_result,
  output logic                 mem_ready,
  output logic                 access_fault
);

  localparam logic [2:0] OP_B  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_W  = 3'd2;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_HU = 3'd5;

  // Counter must be able to hold the timeout limit.
  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_err
    $error("CNT_W too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  lop_q, lop_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] lr_q, lr_d;
  logic        fault_q, fault_d;
`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        op_c;
  logic        is_wr_c;
  logic        illegal_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] lane_c;
  logic [31:0] load_fmt_c;

  // Issue-side decode of the EX/MEM latch; write wins over read.
  always_comb begin
    op_c    = ex_valid & (mem_read | mem_write);
    is_wr_c = mem_write;
    if (is_wr_c) begin
      illegal_c = (store_op >= 3'd3) ||
                  ((store_op == OP_H) && addr[0]) ||
                  ((store_op == OP_W) && (addr[1:0] != 2'b00));
    end else begin
      illegal_c = (load_op == 3'b011) || (load_op[2:1] == 2'b11) ||
                  ((load_op == OP_W) && (addr[1:0] != 2'b00)) ||
                  (((load_op == OP_H) || (load_op == OP_HU)) && addr[0]);
    end
  end

  // Byte mask and lane-replicated write data.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    if (is_wr_c) begin
      case (store_op)
        OP_B: begin
          be_c    = 4'b0001 << addr[1:0];
          wdata_c = {4{store_data[7:0]}};
        end
        OP_H: begin
          be_c    = 4'b0011 << addr[1:0];
          wdata_c = {2{store_data[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = store_data;
        end
      endcase
    end
  end

  // Load formatting from the lane latched at issue.
  always_comb begin
    lane_c = dmem.dmem_rdata >> {off_q, 3'b000};
    case (lop_q)
      OP_B:    load_fmt_c = {{24{lane_c[7]}}, lane_c[7:0]};
      OP_H:    load_fmt_c = {{16{lane_c[15]}}, lane_c[15:0]};
      OP_BU:   load_fmt_c = {24'h0, lane_c[7:0]};
      OP_HU:   load_fmt_c = {16'h0, lane_c[15:0]};
      default: load_fmt_c = dmem.dmem_rdata;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      lop_q   <= 3'h0;
      off_q   <= 2'h0;
      lr_q    <= 32'h0;
      fault_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      lop_q   <= lop_d;
      off_q   <= off_d;
      lr_q    <= lr_d;
      fault_q <= fault_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    lop_d     = lop_q;
    off_d     = off_q;
    lr_d      = lr_q;
    fault_d   = 1'b0;
    mem_ready = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!op_c) begin
          mem_ready = 1'b1;
        end else if (illegal_c) begin
          fault_d = 1'b1;
          lr_d    = 32'h0;
          state_d = ST_DONE;
        end else begin
          rd_d    = ~is_wr_c;
          wr_d    = is_wr_c;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = wdata_c;
          be_d    = be_c;
          lop_d   = load_op;
          off_d   = addr[1:0];
          state_d = ST_ACCESS;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_ACCESS: begin
        if (dmem.dmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) lr_d = load_fmt_c;
          state_d = ST_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        // A response in the timeout cycle takes priority (branch above).
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          lr_d    = 32'h0;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        // Inputs deliberately ignored here so a stalled op is not reissued.
        mem_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dmem.dmem_read        = rd_q;
  assign dmem.dmem_write       = wr_q;
  assign dmem.dmem_address     = addr_q;
  assign dmem.dmem_wdata       = wdata_q;
  assign dmem.dmem_byte_enable = be_q;
  assign load_result           = lr_q;
  assign access_fault          = fault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: a driver issues directed and random
// memory ops and pushes expected requests/completions; a memory responder
// replies after a chosen delay; a monitor pops and compares.
module tb_dmem_access_unit;

`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TO   = 4;
  localparam int MAX_DLY = 3;
`else
  localparam int TB_TO   = 255;
  localparam int MAX_DLY = 6;
`endif

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  store_op;
  logic [2:0]  load_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_result;
  logic        mem_ready;
  logic        access_fault;

  dmem_access_unit_if mif ();

  dmem_access_unit #(.TIMEOUT_CYCLES(TB_TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .store_op     (store_op),
    .load_op      (load_op),
    .addr         (addr),
    .store_data   (store_data),
    .dmem         (mif.master),
    .load_result  (load_result),
    .mem_ready    (mem_ready),
    .access_fault (access_fault)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;
  typedef struct {
    logic        fault;
    logic [31:0] lr;
  } cmp_t;
  typedef struct {
    int          dly;
    logic [31:0] rdata;
  } rsp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];
  rsp_t rsp_q[$];

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model_lr = 32'h0;
  bit          hold_resp = 0;
  bit          stray_req = 0;
  bit          mon_en = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference load formatting: pick the byte lane, then size/sign rules.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = d >> (8 * int'(off));
    b = v % 256;
    h = v % 65536;
    case (op)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // Issue one op, build expectations, wait for completion and check stall length.
  // dly < 0 means the memory never answers (timeout build only).
  task automatic issue(input logic rd, input logic wr, input logic [2:0] sop,
                       input logic [2:0] lop, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdat, input int dly);
    int   sz;
    bit   legal;
    req_t r;
    cmp_t c;
    rsp_t s;
    int   low;
    int   exp_low;
    logic [3:0] m;
    if (wr) begin
      legal = (sop <= 3'd2);
      sz    = 1 << sop[1:0];
    end else begin
      legal = (lop inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz    = 1 << lop[1:0];
    end
    if (legal && ((int'(a[1:0]) % sz) != 0)) legal = 0;
    if (!legal) begin
      model_lr = 32'h0;
      c.fault  = 1'b1;
      exp_low  = 1;
    end else begin
      r.wr   = wr;
      r.addr = a & ~32'h3;
      m      = 4'((1 << sz) - 1);
      r.be   = wr ? (m << a[1:0]) : 4'hF;
      if (sop == 3'd0)      r.wdata = 32'(sd[7:0]) * 32'h0101_0101;
      else if (sop == 3'd1) r.wdata = 32'(sd[15:0]) * 32'h0001_0001;
      else                  r.wdata = sd;
      req_q.push_back(r);
      if (dly >= 0) begin
        s.dly   = dly;
        s.rdata = rdat;
        rsp_q.push_back(s);
        if (!wr) model_lr = model_load(lop, a[1:0], rdat);
        c.fault = 1'b0;
        exp_low = dly + 2;
      end else begin
        model_lr = 32'h0;
        c.fault  = 1'b1;
        exp_low  = TB_TO + 1;
      end
    end
    c.lr = model_lr;
    cmp_q.push_back(c);
    ex_valid   = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    store_op   = sop;
    load_op    = lop;
    addr       = a;
    store_data = sd;
    low = 1;
    @(negedge clk);
    while (!mem_ready && low < 1000) begin
      low++;
      @(negedge clk);
    end
    chk("mem_ready_latency", 32'(low), 32'(exp_low));
    @(posedge clk);
    #1;
    ex_valid   = 1'b0;
    mem_read   = 1'($urandom_range(0, 1));
    mem_write  = 1'($urandom_range(0, 1));
    addr       = $urandom;
    store_data = $urandom;
    @(negedge clk);
  endtask

  // Memory responder.
  initial begin
    int          cnt;
    logic [31:0] cur;
    bit          active;
    rsp_t        s;
    cnt = 0;
    cur = 32'h0;
    active = 0;
    mif.dmem_resp  = 1'b0;
    mif.dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mif.dmem_resp  = 1'b0;
      mif.dmem_rdata = $urandom;
      if (stray_req) begin
        mif.dmem_resp = 1'b1;
        stray_req     = 0;
      end else if (!rst && !hold_resp && (mif.dmem_read || mif.dmem_write)) begin
        if (!active) begin
          if (rsp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL responder: request with no response scheduled, got 1 expected 0");
          end else begin
            s      = rsp_q.pop_front();
            cnt    = s.dly;
            cur    = s.rdata;
            active = 1;
          end
        end
        if (active) begin
          if (cnt == 0) begin
            mif.dmem_resp  = 1'b1;
            mif.dmem_rdata = cur;
            active         = 0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: compares request fields on request rise, stability while held,
  // and fault/load_result on each completion (rising mem_ready).
  initial begin
    bit   req_prev;
    bit   mr_prev;
    bit   req;
    bit   done;
    req_t cur;
    req_t r;
    cmp_t c;
    req_prev = 0;
    mr_prev  = 1;
    cur      = '{wr: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
    forever begin
      @(negedge clk);
      #1;
      req  = mif.dmem_read || mif.dmem_write;
      done = mem_ready && !mr_prev;
      if (!rst) begin
        if (req && !req_prev) begin
          if (req_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_request: got addr %h expected no request", mif.dmem_address);
          end else begin
            r   = req_q.pop_front();
            cur = r;
            chk("req_write", 32'(mif.dmem_write), 32'(r.wr));
            chk("req_read", 32'(mif.dmem_read), 32'(!r.wr));
            chk("req_address", mif.dmem_address, r.addr);
            chk("req_byte_enable", 32'(mif.dmem_byte_enable), 32'(r.be));
            if (r.wr) chk("req_wdata", mif.dmem_wdata, r.wdata);
          end
        end else if (req && req_prev) begin
          chk("req_stable_address", mif.dmem_address, cur.addr);
          chk("req_stable_be", 32'(mif.dmem_byte_enable), 32'(cur.be));
          if (cur.wr) chk("req_stable_wdata", mif.dmem_wdata, cur.wdata);
        end
        if (mon_en && done) begin
          if (cmp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_completion: got mem_ready 1 expected 0");
          end else begin
            c = cmp_q.pop_front();
            chk("done_access_fault", 32'(access_fault), 32'(c.fault));
            chk("done_load_result", load_result, c.lr);
            chk("done_request_low", 32'(req), 32'(0));
          end
        end else if (mon_en && access_fault) begin
          n_chk++;
          n_err++;
          $display("FAIL stray_access_fault: got 1 expected 0");
        end
      end
      req_prev = req;
      mr_prev  = mem_ready;
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dly;
    logic        rd;
    logic        wr;
    ex_valid   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    store_op   = 3'd0;
    load_op    = 3'd0;
    addr       = 32'h0;
    store_data = 32'h0;
    rst        = 1'b1;
    #1;
    chk("reset_dmem_read", 32'(mif.dmem_read), 32'(0));
    chk("reset_dmem_write", 32'(mif.dmem_write), 32'(0));
    chk("reset_dmem_address", mif.dmem_address, 32'h0);
    chk("reset_byte_enable", 32'(mif.dmem_byte_enable), 32'(0));
    chk("reset_load_result", load_result, 32'h0);
    chk("reset_access_fault", 32'(access_fault), 32'(0));
    chk("reset_mem_ready", 32'(mem_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(1, 0, 3'd0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2);  // lb sign-extend
    issue(0, 1, 3'd1, 3'd0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1);  // sh upper half
    issue(1, 0, 3'd0, 3'd2, 32'h0000_3001, 32'h0, 32'h0, 0);          // misaligned lw
    issue(1, 0, 3'd0, 3'd5, 32'h0000_0010, 32'h0, 32'h8001_F00F, 0);  // lhu, resp same cycle
    issue(1, 1, 3'd0, 3'd2, 32'h0000_4003, 32'h0000_005A, 32'h0, 1);  // both set: sb wins
    issue(1, 0, 3'd0, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 0);          // illegal load op
    issue(1, 0, 3'd0, 3'd2, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 4);  // lw pass-through
    issue(0, 1, 3'd2, 3'd0, 32'h0000_0104, 32'h1234_5678, 32'h0, 0);  // sw, lr unchanged
    issue(0, 1, 3'd3, 3'd0, 32'h0000_0100, 32'h0, 32'h0, 0);          // illegal store op
    issue(0, 1, 3'd2, 3'd0, 32'h0000_0022, 32'h0, 32'h0, 0);          // misaligned sw
    issue(1, 0, 3'd0, 3'd1, 32'h0000_2001, 32'h0, 32'h0, 0);          // misaligned lh
    issue(1, 0, 3'd0, 3'd0, 32'h0000_6001, 32'h0, 32'h0000_7F00, 1);  // lb positive
    issue(1, 0, 3'd0, 3'd1, 32'h0000_6002, 32'h0, 32'hC123_0000, 3);  // lh upper lane

    // Reset in the middle of an access, then a stray response in IDLE.
    hold_resp = 1;
    mon_en    = 0;
    req_q.push_back('{wr: 1'b0, addr: 32'h0000_0200, wdata: 32'h0, be: 4'hF});
    ex_valid  = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    load_op   = 3'd2;
    addr      = 32'h0000_0200;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_read_high", 32'(mif.dmem_read), 32'(1));
    #2;
    rst      = 1'b1;
    ex_valid = 1'b0;
    #1;
    chk("midreset_dmem_read", 32'(mif.dmem_read), 32'(0));
    chk("midreset_dmem_address", mif.dmem_address, 32'h0);
    chk("midreset_load_result", load_result, 32'h0);
    chk("midreset_mem_ready", 32'(mem_ready), 32'(1));
    @(negedge clk);
    rst       = 1'b0;
    stray_req = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("stray_resp_load_result", load_result, 32'h0);
    chk("stray_resp_no_request", 32'(mif.dmem_read || mif.dmem_write), 32'(0));
    chk("stray_resp_fault", 32'(access_fault), 32'(0));
    model_lr  = 32'h0;
    hold_resp = 0;
    mon_en    = 1;

`ifdef DMEM_TIMEOUT_EN
    hold_resp = 1;
    issue(1, 0, 3'd0, 3'd2, 32'h0000_7000, 32'h0, 32'h0, -1);         // read timeout
    hold_resp = 0;
    issue(1, 0, 3'd0, 3'd2, 32'h0000_7004, 32'h0, 32'h1111_2222, 3);  // resp wins at limit
    hold_resp = 1;
    issue(0, 1, 3'd0, 3'd0, 32'h0000_7001, 32'h0000_0033, 32'h0, -1); // store timeout
    hold_resp = 0;
`endif

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = $urandom_range(0, MAX_DLY);
      issue(rd, wr, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, dly);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("req_queue_empty", 32'(req_q.size()), 32'(0));
    chk("cmp_queue_empty", 32'(cmp_q.size()), 32'(0));
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
